// File: rtl/imm_gen_pkg.sv
// Shared constants for the pipelined RISC-V immediate generator:
// format codes and the base-ISA opcodes that carry an immediate.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_NONE = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

endpackage

// File: rtl/imm_fmt_decode.sv
// Combinational opcode decode: maps an opcode to an immediate format code
// and flags opcodes that carry no immediate for this XLEN.
module imm_fmt_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [6:0] opcode,
  output logic [2:0] fmt,
  output logic       illegal
);

  always_comb begin
    fmt     = FMT_NONE;
    illegal = 1'b1;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
        fmt     = FMT_I;
        illegal = 1'b0;
      end
      OPC_OP_IMM_32: begin
        // word-sized ops only exist on RV64
        if (XLEN == 64) begin
          fmt     = FMT_I;
          illegal = 1'b0;
        end
      end
      OPC_STORE: begin
        fmt     = FMT_S;
        illegal = 1'b0;
      end
      OPC_BRANCH: begin
        fmt     = FMT_B;
        illegal = 1'b0;
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt     = FMT_U;
        illegal = 1'b0;
      end
      OPC_JAL: begin
        fmt     = FMT_J;
        illegal = 1'b0;
      end
      default: begin
        fmt     = FMT_NONE;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage valid/ready immediate generator: stage 1 holds the instruction and
// its decoded format, stage 2 holds the assembled XLEN immediate for the consumer.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 4,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [ERR_W-1:0] err_count
);

  logic             s1_valid_q, s1_valid_d;
  logic [31:7]      s1_inst_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [2:0]       s1_fmt_q;
  logic             s1_illegal_q;

  logic             s2_valid_q, s2_valid_d;
  logic [XLEN-1:0]  s2_imm_q, s2_imm_d;
  logic [2:0]       s2_fmt_q;
  logic             s2_illegal_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic [ERR_W-1:0] err_q, err_d;

  logic [2:0]       dec_fmt;
  logic             dec_illegal;
  logic             s1_free, s2_free, s1_load, s2_load, out_fire;
  logic [31:0]      imm32;

  imm_fmt_decode #(.XLEN(XLEN)) u_dec (
    .opcode  (in_inst[6:0]),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  // A stage may take new data when empty or when its occupant leaves this cycle.
  assign s2_free  = !s2_valid_q || out_ready;
  assign s1_free  = !s1_valid_q || s2_free;
  assign in_ready = s1_free;
  assign s1_load  = in_valid && s1_free;
  assign s2_load  = s1_valid_q && s2_free;
  assign out_fire = s2_valid_q && out_ready;

  always_comb begin
    s1_valid_d = s1_free ? in_valid : s1_valid_q;
    s2_valid_d = s2_free ? s1_valid_q : s2_valid_q;
  end

  always_comb begin
    imm32 = '0;
    case (s1_fmt_q)
      FMT_I: imm32 = {{20{s1_inst_q[31]}}, s1_inst_q[31:20]};
      FMT_S: imm32 = {{20{s1_inst_q[31]}}, s1_inst_q[31:25], s1_inst_q[11:7]};
      FMT_B: imm32 = {{19{s1_inst_q[31]}}, s1_inst_q[31], s1_inst_q[7],
                      s1_inst_q[30:25], s1_inst_q[11:8], 1'b0};
      FMT_U: imm32 = {s1_inst_q[31:12], 12'b0};
      FMT_J: imm32 = {{11{s1_inst_q[31]}}, s1_inst_q[31], s1_inst_q[19:12],
                      s1_inst_q[20], s1_inst_q[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    // every format is at most 32 bits wide, so widening to XLEN is a plain sign extension
    s2_imm_d = XLEN'(signed'(imm32));
  end

  always_comb begin
    err_d = err_q;
    if (out_fire && s2_illegal_q && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_inst_q    <= '0;
      s1_tag_q     <= '0;
      s1_fmt_q     <= FMT_NONE;
      s1_illegal_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_inst_q    <= in_inst[31:7];
        s1_tag_q     <= in_tag;
        s1_fmt_q     <= dec_fmt;
        s1_illegal_q <= dec_illegal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q   <= 1'b0;
      s2_imm_q     <= '0;
      s2_fmt_q     <= FMT_NONE;
      s2_illegal_q <= 1'b0;
      s2_tag_q     <= '0;
      err_q        <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      err_q      <= err_d;
      if (s2_load) begin
        s2_imm_q     <= s2_imm_d;
        s2_fmt_q     <= s1_fmt_q;
        s2_illegal_q <= s1_illegal_q;
        s2_tag_q     <= s1_tag_q;
      end
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_imm     = s2_imm_q;
  assign out_fmt     = s2_fmt_q;
  assign out_illegal = s2_illegal_q;
  assign out_tag     = s2_tag_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an RV64 and an RV32 (2-bit counter) instance share one
// stimulus stream and are checked against a queue-based reference model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic [3:0]  in_tag = '0;
  logic        out_ready = 1'b1;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic [3:0]  out_tag64;
  logic [15:0] err64;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;
  logic [3:0]  out_tag32;
  logic [1:0]  err32;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .TAG_W(4), .ERR_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64),
    .out_tag(out_tag64), .err_count(err64)
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(4), .ERR_W(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_illegal32),
    .out_tag(out_tag32), .err_count(err32)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference immediate computed arithmetically from the ISA field layout.
  function automatic void ref_imm(input logic [31:0] inst, input int xlen,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output logic ill);
    longint v;
    logic signed [11:0] s12;
    logic signed [12:0] s13;
    logic signed [20:0] s21;
    logic signed [31:0] s32;
    v = 0; fmt = 3'd7; ill = 1'b1;
    case (inst[6:0])
      7'h03, 7'h13, 7'h67: begin s12 = inst[31:20]; v = s12; fmt = 3'd0; ill = 1'b0; end
      7'h1B: if (xlen == 64) begin s12 = inst[31:20]; v = s12; fmt = 3'd0; ill = 1'b0; end
      7'h23: begin s12 = {inst[31:25], inst[11:7]}; v = s12; fmt = 3'd1; ill = 1'b0; end
      7'h63: begin
        s13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        v = s13; fmt = 3'd2; ill = 1'b0;
      end
      7'h37, 7'h17: begin s32 = {inst[31:12], 12'b0}; v = s32; fmt = 3'd3; ill = 1'b0; end
      7'h6F: begin
        s21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        v = s21; fmt = 3'd4; ill = 1'b0;
      end
      default: ;
    endcase
    imm = (xlen == 32) ? {32'b0, v[31:0]} : v;
  endfunction

  typedef struct {
    logic [63:0] imm64, imm32;
    logic [2:0]  fmt64, fmt32;
    logic        ill64, ill32;
    logic [3:0]  tag;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   negc = 0;
  int   cnt64 = 0;
  int   cnt32 = 0;

  // Occupancy model: the oldest item reaches the output two cycles after it is
  // accepted, and at most two items can be in flight.
  always @(negedge clk) begin
    logic ev, er;
    exp_t e;
    negc++;
    if (!rst_n) begin
      q.delete();
      cnt64 = 0;
      cnt32 = 0;
    end else begin
      ev = (q.size() > 0) && (q[0].acc <= negc - 2);
      er = (q.size() < 2) || out_ready;
      chk("out_valid64", 64'(out_valid64), 64'(ev));
      chk("out_valid32", 64'(out_valid32), 64'(ev));
      chk("in_ready64", 64'(in_ready64), 64'(er));
      chk("in_ready32", 64'(in_ready32), 64'(er));
      chk("err64", 64'(err64), 64'(cnt64));
      chk("err32", 64'(err32), 64'(cnt32));
      if (ev) begin
        chk("imm64", out_imm64, q[0].imm64);
        chk("fmt64", 64'(out_fmt64), 64'(q[0].fmt64));
        chk("ill64", 64'(out_illegal64), 64'(q[0].ill64));
        chk("tag64", 64'(out_tag64), 64'(q[0].tag));
        chk("imm32", {32'b0, out_imm32}, q[0].imm32);
        chk("fmt32", 64'(out_fmt32), 64'(q[0].fmt32));
        chk("ill32", 64'(out_illegal32), 64'(q[0].ill32));
        chk("tag32", 64'(out_tag32), 64'(q[0].tag));
        if (out_ready) begin
          e = q.pop_front();
          if (e.ill64 && cnt64 < 65535) cnt64++;
          if (e.ill32 && cnt32 < 3) cnt32++;
        end
      end
      if (in_valid && er) begin
        ref_imm(in_inst, 64, e.imm64, e.fmt64, e.ill64);
        ref_imm(in_inst, 32, e.imm32, e.fmt32, e.ill32);
        e.tag = in_tag;
        e.acc = negc;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [31:0] inst, input logic [3:0] tag);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_tag   = tag;
    forever begin
      @(negedge clk);
      if (in_ready64) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_inst  = $urandom;
  endtask

  logic [6:0] ops [9] = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

  initial begin
    logic [31:0] r;
    logic [6:0]  op;
    logic [3:0]  held_tag;
    logic [63:0] held_imm;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_imm", out_imm64, 64'd0);
    chk("rst_fmt", 64'(out_fmt64), 64'd7);
    chk("rst_ill", 64'(out_illegal64), 64'd0);
    chk("rst_tag", 64'(out_tag64), 64'd0);
    chk("rst_err", 64'(err64), 64'd0);
    @(posedge clk); #1;

    // lw x1,-4(x2)
    send(32'hFFC12083, 4'd3);
    @(negedge clk);
    chk("lw_lat_early", 64'(out_valid64), 64'd0);
    @(negedge clk);
    chk("lw_valid", 64'(out_valid64), 64'd1);
    chk("lw_imm", out_imm64, 64'hFFFFFFFFFFFFFFFC);
    chk("lw_fmt", 64'(out_fmt64), 64'd0);
    chk("lw_ill", 64'(out_illegal64), 64'd0);
    @(posedge clk); #1;

    // beq x0,x0,-8
    send(32'hFE000CE3, 4'd4);
    @(negedge clk); @(negedge clk);
    chk("beq_imm", out_imm64, 64'hFFFFFFFFFFFFFFF8);
    chk("beq_fmt", 64'(out_fmt64), 64'd2);
    @(posedge clk); #1;

    // lui then jal back-to-back
    send(32'h800002B7, 4'd1);
    send(32'h0010006F, 4'd2);
    @(negedge clk);
    chk("lui_imm", out_imm64, 64'hFFFFFFFF80000000);
    chk("lui_tag", 64'(out_tag64), 64'd1);
    chk("lui_imm32", 64'(out_imm32), 64'h80000000);
    @(negedge clk);
    chk("jal_imm", out_imm64, 64'h0000000000000800);
    chk("jal_tag", 64'(out_tag64), 64'd2);
    chk("jal_fmt", 64'(out_fmt64), 64'd4);
    @(posedge clk); #1;

    // illegal opcodes; OP-IMM-32 only illegal on RV32
    send(32'h00000000, 4'd5);
    send(32'h0000001B, 4'd6);
    @(negedge clk);
    chk("ill0_ill", 64'(out_illegal64), 64'd1);
    chk("ill0_imm", out_imm64, 64'd0);
    chk("ill0_fmt", 64'(out_fmt64), 64'd7);
    @(negedge clk);
    chk("w32_ill32", 64'(out_illegal32), 64'd1);
    chk("w32_imm32", 64'(out_imm32), 64'd0);
    chk("w32_fmt32", 64'(out_fmt32), 64'd7);
    chk("w32_ill64", 64'(out_illegal64), 64'd0);
    @(negedge clk);
    chk("err32_two", 64'(err32), 64'd2);
    chk("err64_one", 64'(err64), 64'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send(32'h0000007F, 4'(i));
    repeat (3) @(negedge clk);
    chk("err32_sat", 64'(err32), 64'd3);
    chk("err64_six", 64'(err64), 64'd6);
    @(posedge clk); #1;

    // backpressure: fill both stages, hold, then release with an input waiting
    out_ready = 1'b0;
    send(32'h00100093, 4'd0);
    send(32'h00200113, 4'd1);
    fork
      begin
        send(32'h00300193, 4'd2);
        send(32'h00400213, 4'd3);
        send(32'h00500293, 4'd4);
      end
      begin
        @(negedge clk);
        chk("bp_full", 64'(in_ready64), 64'd0);
        held_tag = out_tag64;
        held_imm = out_imm64;
        repeat (3) @(negedge clk);
        chk("bp_hold_tag", 64'(out_tag64), 64'(held_tag));
        chk("bp_hold_imm", out_imm64, held_imm);
        chk("bp_head_tag", 64'(out_tag64), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // reset with both stages full
    out_ready = 1'b0;
    send(32'h00000013, 4'd7);
    send(32'h00000000, 4'd8);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(out_valid64), 64'd0);
    chk("rst_mid_err", 64'(err64), 64'd0);
    chk("rst_mid_err32", 64'(err32), 64'd0);
    chk("rst_mid_ready", 64'(in_ready64), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(32'hFFC12083, 4'd9);
    @(negedge clk);
    chk("post_rst_early", 64'(out_valid64), 64'd0);
    @(negedge clk);
    chk("post_rst_valid", 64'(out_valid64), 64'd1);
    chk("post_rst_tag", 64'(out_tag64), 64'd9);
    @(posedge clk); #1;

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      r = $urandom;
      op = (r[3:0] < 4'd9) ? ops[r[3:0]] : r[10:4];
      r = $urandom;
      in_inst   = {r[31:7], op};
      in_tag    = 4'($urandom_range(0, 15));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
